// File: rtl/uart_tx_arbiter_if.sv
// Source handshakes and transmitter-side signals shared by uart_tx_arbiter and its environment.
// The master modport is the arbiter; the slave modport is the producers plus transmitter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ack;
   logic [7:0]           tx_data_o;
   logic                 tx_start_n;
   logic                 tx_busy_i;
   logic [IDW-1:0]       grant_id;
   logic                 grant_active;
   logic                 err_timeout;

   modport master (
      input  req_valid, req_data, tx_busy_i,
      output req_ack, tx_data_o, tx_start_n, grant_id, grant_active, err_timeout
   );

   modport slave (
      output req_valid, req_data, tx_busy_i,
      input  req_ack, tx_data_o, tx_start_n, grant_id, grant_active, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ byte sources.
// One byte per frame: capture, one-cycle start strobe, then follow tx_busy_i to frame end.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              rstn,
   uart_tx_arbiter_if.master bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);
   localparam logic [TW-1:0]  TIMER_LAST = TW'((BUSY_TIMEOUT > 1) ? BUSY_TIMEOUT - 2 : 0);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t             state, state_nxt;
   logic [IDW-1:0]     rr_ptr, rr_ptr_nxt;
   logic [TW-1:0]      timer, timer_nxt;
   logic [NUM_REQ-1:0] ack_q, ack_nxt;
   logic [7:0]         data_q, data_nxt;
   logic               start_n_q, start_n_nxt;
   logic [IDW-1:0]     grant_id_q, grant_id_nxt;
   logic               active_q, active_nxt;
   logic               err_q, err_nxt;

   logic               found;
   logic [IDW-1:0]     winner;
   logic [IDW-1:0]     scan;
   logic [7:0]         win_data;

   // Scan from rr_ptr upward with wrap; the first pending source wins.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      win_data = '0;
      scan     = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.req_valid[scan]) begin
            found  = 1'b1;
            winner = scan;
         end
         scan = (scan == LAST_ID) ? '0 : scan + IDW'(1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == winner) win_data = bus.req_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         timer      <= '0;
         ack_q      <= '0;
         data_q     <= '0;
         start_n_q  <= 1'b1;
         grant_id_q <= '0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         timer      <= timer_nxt;
         ack_q      <= ack_nxt;
         data_q     <= data_nxt;
         start_n_q  <= start_n_nxt;
         grant_id_q <= grant_id_nxt;
         active_q   <= active_nxt;
         err_q      <= err_nxt;
      end
   end

   // A busy transmitter in IDLE belongs to someone else, so no grant is made.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!bus.tx_busy_i && found) state_nxt = LAUNCH;
         LAUNCH:    state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (bus.tx_busy_i)          state_nxt = WAIT_DONE;
            else if (timer >= TIMER_LAST) state_nxt = IDLE;
         end
         WAIT_DONE: if (!bus.tx_busy_i) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Timeout fires on the edge where the incremented timer would reach BUSY_TIMEOUT-1.
   always_comb begin
      ack_nxt      = '0;
      start_n_nxt  = 1'b1;
      err_nxt      = 1'b0;
      data_nxt     = data_q;
      grant_id_nxt = grant_id_q;
      active_nxt   = active_q;
      rr_ptr_nxt   = rr_ptr;
      timer_nxt    = timer;
      case (state)
         IDLE: begin
            if (!bus.tx_busy_i && found) begin
               ack_nxt      = NUM_REQ'(1) << winner;
               start_n_nxt  = 1'b0;
               data_nxt     = win_data;
               grant_id_nxt = winner;
               active_nxt   = 1'b1;
               rr_ptr_nxt   = (winner == LAST_ID) ? '0 : winner + IDW'(1);
            end
         end
         LAUNCH:    timer_nxt = '0;
         WAIT_BUSY: begin
            if (!bus.tx_busy_i) begin
               if (timer >= TIMER_LAST) begin
                  err_nxt    = 1'b1;
                  active_nxt = 1'b0;
               end else begin
                  timer_nxt = timer + TW'(1);
               end
            end
         end
         WAIT_DONE: if (!bus.tx_busy_i) active_nxt = 1'b0;
         default:   ;
      endcase
   end

   assign bus.req_ack      = ack_q;
   assign bus.tx_data_o    = data_q;
   assign bus.tx_start_n   = start_n_q;
   assign bus.grant_id     = grant_id_q;
   assign bus.grant_active = active_q;
   assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// and a randomized run against a frame-level round-robin reference model.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ      = 4;
   localparam int BUSY_TIMEOUT = 4;
   localparam int NEVER        = 1000000000;

   typedef struct {
      logic [NUM_REQ-1:0]   mask;
      logic [8*NUM_REQ-1:0] data;
      int                   busy_len;
      int                   exp_win;
      logic [7:0]           exp_data;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;
   int   t          = 0;
   vec_t vecs[12];

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 2 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at sample %0d: got 0x%0h, expected 0x%0h", name, t, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ack"},     32'(bus.req_ack), 32'd0);
      checkOutput({tag, "_start_n"}, 32'(bus.tx_start_n), 32'd1);
      checkOutput({tag, "_data"},    32'(bus.tx_data_o), 32'd0);
      checkOutput({tag, "_id"},      32'(bus.grant_id), 32'd0);
      checkOutput({tag, "_active"},  32'(bus.grant_active), 32'd0);
      checkOutput({tag, "_err"},     32'(bus.err_timeout), 32'd0);
   endtask

   task automatic doReset();
      rstn          = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_busy_i = 1'b0;
      step();
      step();
      checkResetOutputs("reset");
      rstn = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.req_valid = v.mask;
      bus.req_data  = v.data;
   endtask

   // Waits (bounded) for the strobe, then checks what was captured in that cycle.
   task automatic captureCheck(input string tag, input int exp_win, input logic [7:0] exp_data);
      int n;
      n = 0;
      while (bus.tx_start_n !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      checkOutput({tag, "_strobe"}, 32'(bus.tx_start_n), 32'd0);
      checkOutput({tag, "_ack"},    32'(bus.req_ack), 32'd1 << exp_win);
      checkOutput({tag, "_id"},     32'(bus.grant_id), 32'(exp_win));
      checkOutput({tag, "_data"},   32'(bus.tx_data_o), 32'(exp_data));
      checkOutput({tag, "_active"}, 32'(bus.grant_active), 32'd1);
   endtask

   // Transmitter goes busy one cycle after the strobe, for busy_len cycles.
   task automatic finishFrame(input string tag, input int busy_len);
      step();
      checkOutput({tag, "_strobe_1cyc"}, 32'(bus.tx_start_n), 32'd1);
      checkOutput({tag, "_ack_1cyc"},    32'(bus.req_ack), 32'd0);
      bus.tx_busy_i = 1'b1;
      for (int k = 0; k < busy_len; k++) begin
         step();
         if (bus.tx_start_n !== 1'b1 || bus.req_ack !== '0 || bus.grant_active !== 1'b1)
            checkOutput({tag, "_quiet_busy"},
                        {29'd0, bus.tx_start_n, |bus.req_ack, bus.grant_active}, 32'b101);
      end
      compared++;
      bus.tx_busy_i = 1'b0;
      step();
      checkOutput({tag, "_active_drop"}, 32'(bus.grant_active), 32'd0);
   endtask

   function automatic int pickWinner(input logic [NUM_REQ-1:0] v, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic runRandom(input int cycles);
      logic [NUM_REQ-1:0] v;
      logic [7:0]         d[NUM_REQ];
      int                 rr, idle_from, err_at, rise_at, fall_at, exp_win;
      bit                 exp_grant;
      logic [7:0]         exp_dat;
      v         = '0;
      rr        = 0;
      idle_from = t;
      err_at    = -1;
      rise_at   = -1;
      fall_at   = -1;
      exp_win   = -1;
      exp_grant = 1'b0;
      exp_dat   = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) d[i] = 8'h00;
      for (int c = 0; c < cycles; c++) begin
         checkOutput("rnd_start_n", 32'(bus.tx_start_n), exp_grant ? 32'd0 : 32'd1);
         checkOutput("rnd_ack", 32'(bus.req_ack), exp_grant ? (32'd1 << exp_win) : 32'd0);
         checkOutput("rnd_active", 32'(bus.grant_active),
                     (exp_grant || t < idle_from) ? 32'd1 : 32'd0);
         checkOutput("rnd_err", 32'(bus.err_timeout), (t == err_at) ? 32'd1 : 32'd0);
         if (exp_grant) begin
            checkOutput("rnd_data", 32'(bus.tx_data_o), 32'(exp_dat));
            checkOutput("rnd_grant_id", 32'(bus.grant_id), 32'(exp_win));
            v[exp_win] = 1'b0;
            rr         = (exp_win + 1) % NUM_REQ;
            idle_from  = NEVER;
            if ($urandom_range(0, 4) == 0) begin
               rise_at   = -1;
               fall_at   = -1;
               err_at    = t + BUSY_TIMEOUT;
               idle_from = t + BUSY_TIMEOUT;
            end else begin
               rise_at = t + int'($urandom_range(1, BUSY_TIMEOUT - 1));
               fall_at = rise_at + int'($urandom_range(1, 6));
            end
         end
         if (t == rise_at) bus.tx_busy_i = 1'b1;
         if (t == fall_at) begin
            bus.tx_busy_i = 1'b0;
            idle_from     = t + 1;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!v[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  v[i] = 1'b1;
                  d[i] = 8'($urandom);
               end
            end else if ($urandom_range(0, 31) == 0) begin
               v[i] = 1'b0;
            end
            bus.req_data[8*i +: 8] = d[i];
         end
         bus.req_valid = v;
         exp_win   = pickWinner(v, rr);
         exp_grant = (t >= idle_from) && !bus.tx_busy_i && (exp_win >= 0);
         if (exp_grant) exp_dat = d[exp_win];
         step();
      end
   endtask

   initial begin
      vecs[0]  = '{4'b0100, 32'h13A51110, 160, 2, 8'hA5};
      vecs[1]  = '{4'b1111, 32'h13121110,   3, 3, 8'h13};
      vecs[2]  = '{4'b1111, 32'h13121110,   2, 0, 8'h10};
      vecs[3]  = '{4'b1010, 32'h13121110,   1, 1, 8'h11};
      vecs[4]  = '{4'b1010, 32'h13121110,   5, 3, 8'h13};
      vecs[5]  = '{4'b1010, 32'h13121110,   2, 1, 8'h11};
      vecs[6]  = '{4'b0001, 32'h13121110,   1, 0, 8'h10};
      vecs[7]  = '{4'b0001, 32'h13121110,   4, 0, 8'h10};
      vecs[8]  = '{4'b1001, 32'h13121110,   2, 3, 8'h13};
      vecs[9]  = '{4'b0110, 32'h44332211,   3, 1, 8'h22};
      vecs[10] = '{4'b0110, 32'h44332211,   1, 2, 8'h33};
      vecs[11] = '{4'b0011, 32'h44332211,   2, 0, 8'h11};

      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_busy_i = 1'b0;
      doReset();

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         captureCheck($sformatf("vec%0d", i), vecs[i].exp_win, vecs[i].exp_data);
         finishFrame($sformatf("vec%0d", i), vecs[i].busy_len);
      end

      // All sources held valid: strict 0,1,2,3,0 with immediate re-grant after each frame.
      doReset();
      bus.req_valid = 4'b1111;
      bus.req_data  = 32'h13121110;
      for (int g = 0; g < 5; g++) begin
         if (g > 0) begin
            step();
            checkOutput("rr_regrant_latency", 32'(bus.tx_start_n), 32'd0);
         end
         captureCheck($sformatf("rr%0d", g), g % NUM_REQ, 8'h10 + 8'(g % NUM_REQ));
         finishFrame($sformatf("rr%0d", g), 3);
      end

      // Transmitter never goes busy: abort after BUSY_TIMEOUT cycles, then grant src1.
      doReset();
      bus.req_valid = 4'b0001;
      bus.req_data  = 32'h13121110;
      captureCheck("to", 0, 8'h10);
      bus.req_valid = 4'b0010;
      for (int k = 1; k < BUSY_TIMEOUT; k++) begin
         step();
         checkOutput("to_err_early", 32'(bus.err_timeout), 32'd0);
         checkOutput("to_active_hold", 32'(bus.grant_active), 32'd1);
      end
      step();
      checkOutput("to_err_pulse", 32'(bus.err_timeout), 32'd1);
      checkOutput("to_active_drop", 32'(bus.grant_active), 32'd0);
      checkOutput("to_no_strobe", 32'(bus.tx_start_n), 32'd1);
      step();
      checkOutput("to_err_clear", 32'(bus.err_timeout), 32'd0);
      captureCheck("to_next", 1, 8'h11);
      finishFrame("to_next", 2);

      // Foreign busy before any request holds off the grant until busy falls.
      doReset();
      bus.tx_busy_i = 1'b1;
      bus.req_valid = 4'b0001;
      bus.req_data  = 32'h13121110;
      for (int k = 0; k < 6; k++) begin
         step();
         checkOutput("fb_no_strobe", 32'(bus.tx_start_n), 32'd1);
         checkOutput("fb_no_ack", 32'(bus.req_ack), 32'd0);
      end
      bus.tx_busy_i = 1'b0;
      step();
      checkOutput("fb_grant_strobe", 32'(bus.tx_start_n), 32'd0);
      checkOutput("fb_grant_ack", 32'(bus.req_ack), 32'd1);
      checkOutput("fb_grant_data", 32'(bus.tx_data_o), 32'h10);
      finishFrame("fb", 2);

      // Reset mid-frame clears everything at once; rr_ptr restarts at 0 (src1 beats src3).
      doReset();
      bus.req_valid = 4'b0010;
      bus.req_data  = 32'h13121110;
      captureCheck("mr", 1, 8'h11);
      bus.req_valid = 4'b0000;
      step();
      bus.tx_busy_i = 1'b1;
      step();
      step();
      bus.req_valid = 4'b1010;
      bus.req_data  = 32'h13127710;
      #2;
      rstn = 1'b0;
      #1;
      checkResetOutputs("mr_async");
      bus.tx_busy_i = 1'b0;
      step();
      rstn = 1'b1;
      step();
      checkOutput("mr_strobe", 32'(bus.tx_start_n), 32'd0);
      checkOutput("mr_ack", 32'(bus.req_ack), 32'b0010);
      checkOutput("mr_id", 32'(bus.grant_id), 32'd1);
      checkOutput("mr_data", 32'(bus.tx_data_o), 32'h77);
      finishFrame("mr", 2);

      doReset();
      runRandom(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
